// File: rtl/lsu_mem_ctrl_if.sv
// Core-side load/store request and response bus of the LSU memory front end.
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32 load/store front end for a 1-cycle synchronous-read word RAM, with
// read-modify-write for sub-word stores and request error detection.
module lsu_mem_ctrl #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned MEM_WORDS = 16384
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_mem_ctrl_if.slave     bus,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_r_addr,
    input  logic [31:0]       ram_r_data,
    output logic [ADDR_W-1:0] ram_w_addr,
    output logic [31:0]       ram_w_data
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        DATA = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t             state, state_next;
    logic [ADDR_W+1:0]  addr_q;
    logic               we_q;
    logic [2:0]         funct3_q;
    logic [31:0]        wdata_q;

    logic               accept_c;
    logic               req_err_c;
    logic               legal_f3_c;
    logic               misaligned_c;
    logic               out_of_range_c;
    logic [4:0]         lane_sh_c;
    logic [31:0]        rd_shift_c;
    logic [31:0]        load_data_c;
    logic [31:0]        lane_mask_c;
    logic [31:0]        merged_c;

    assign accept_c   = bus.req_valid && (state == IDLE);
    assign ram_r_addr = addr_q[ADDR_W+1:2];
    assign ram_w_addr = addr_q[ADDR_W+1:2];

    // Request legality, evaluated on the live request at the accepting edge.
    always_comb begin
        legal_f3_c = 1'b0;
        if (bus.req_we) begin
            legal_f3_c = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                         (bus.req_funct3 == 3'b010);
        end else begin
            legal_f3_c = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                         (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                         (bus.req_funct3 == 3'b101);
        end
        misaligned_c   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                         ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        out_of_range_c = ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS));
        req_err_c      = !legal_f3_c || misaligned_c || out_of_range_c;
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        lane_sh_c   = {addr_q[1:0], 3'b000};
        rd_shift_c  = ram_r_data >> lane_sh_c;
        load_data_c = 32'h0;
        case (funct3_q)
            3'b000:  load_data_c = {{24{rd_shift_c[7]}}, rd_shift_c[7:0]};
            3'b001:  load_data_c = {{16{rd_shift_c[15]}}, rd_shift_c[15:0]};
            3'b010:  load_data_c = rd_shift_c;
            3'b100:  load_data_c = {24'h0, rd_shift_c[7:0]};
            3'b101:  load_data_c = {16'h0, rd_shift_c[15:0]};
            default: load_data_c = 32'h0;
        endcase
        lane_mask_c = (funct3_q[1:0] == 2'b00) ? (32'h0000_00FF << lane_sh_c)
                                               : (32'h0000_FFFF << lane_sh_c);
        merged_c    = (ram_r_data & ~lane_mask_c) | ((wdata_q << lane_sh_c) & lane_mask_c);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (req_err_c)                                   state_next = RESP;
                    else if (bus.req_we && bus.req_funct3 == 3'b010) state_next = WR;
                    else                                             state_next = RD;
                end
            end
            RD:      state_next = DATA;
            DATA:    state_next = RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs; ram_we falls with the asynchronous reset of state.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        ram_we         = 1'b0;
        ram_w_data     = wdata_q;
        case (state)
            IDLE: bus.req_ready  = 1'b1;
            DATA: begin
                ram_we     = we_q;
                ram_w_data = merged_c;
            end
            WR:   ram_we         = 1'b1;
            RESP: bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0;
        end else if (accept_c) begin
            addr_q   <= bus.req_addr[ADDR_W+1:0];
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            wdata_q  <= bus.req_wdata;
        end
    end

    // Response payload is loaded only on the edge that enters RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.resp_rdata <= 32'h0;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c && req_err_c) begin
                        bus.resp_rdata <= 32'h0;
                        bus.resp_err   <= 1'b1;
                    end
                end
                DATA: begin
                    bus.resp_rdata <= we_q ? 32'h0 : load_data_c;
                    bus.resp_err   <= 1'b0;
                end
                WR: begin
                    bus.resp_rdata <= 32'h0;
                    bus.resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized self-checking bench for lsu_mem_ctrl against a byte-level
// reference memory model.
module tb_lsu_mem_ctrl;
    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned MEM_WORDS = 16384;

    logic              clk;
    logic              rst_n;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_r_addr;
    logic [31:0]       ram_r_data;
    logic [ADDR_W-1:0] ram_w_addr;
    logic [31:0]       ram_w_data;
    logic              ram_init;

    lsu_mem_ctrl_if bus ();

    lsu_mem_ctrl #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .ram_we     (ram_we),
        .ram_r_addr (ram_r_addr),
        .ram_r_data (ram_r_data),
        .ram_w_addr (ram_w_addr),
        .ram_w_data (ram_w_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int unsigned i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Behavioural 1-cycle synchronous-read RAM.
    logic [31:0] mem [0:MEM_WORDS-1];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= init_word(i);
        end else if (ram_we) begin
            mem[ram_w_addr] <= ram_w_data;
        end
        ram_r_data <= mem[ram_r_addr];
    end

    logic [31:0] ref_mem [0:MEM_WORDS-1];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, check latency, payload and RAM traffic against the model.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input bit hold, output logic [31:0] rd_obs);
        int unsigned nbytes, off, widx, lat_exp, lat_obs, nwe_obs, k;
        bit legal, err_exp, ready_low;
        logic [31:0] old_w, new_w, mask, rd_exp, b, err_obs;

        legal   = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        nbytes  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err_exp = !legal || ((addr % nbytes) != 0) || ((addr / 4) >= MEM_WORDS);
        off     = addr % 4;
        widx    = (addr / 4) % MEM_WORDS;
        old_w   = ref_mem[widx];
        mask    = (nbytes == 4) ? 32'hFFFF_FFFF : (((32'h1 << (8 * nbytes)) - 1) << (8 * off));
        new_w   = (old_w & ~mask) | ((wd << (8 * off)) & mask);
        b       = (old_w >> (8 * off)) & ((nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 1));
        rd_exp  = 32'h0;
        if (!err_exp && !we) begin
            rd_exp = b;
            if (f3 == 3'd0 && b[7])  rd_exp = b | 32'hFFFF_FF00;
            if (f3 == 3'd1 && b[15]) rd_exp = b | 32'hFFFF_0000;
        end
        lat_exp = err_exp ? 1 : (we && nbytes == 4) ? 2 : 3;

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;

        lat_obs = 0; nwe_obs = 0; ready_low = 1'b1; rd_obs = 32'h0; err_obs = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.req_ready) ready_low = 1'b0;
            if (ram_we) begin
                nwe_obs++;
                check("ram_w_addr", 32'(ram_w_addr), 32'(widx));
                check("ram_w_data", ram_w_data, new_w);
            end
            if (bus.resp_valid) begin
                lat_obs = c;
                rd_obs  = bus.resp_rdata;
                err_obs = 32'(bus.resp_err);
                break;
            end
        end
        check("latency", 32'(lat_obs), 32'(lat_exp));
        check("resp_err", err_obs, 32'(err_exp));
        check("resp_rdata", rd_obs, rd_exp);
        check("ram_we_count", 32'(nwe_obs), (!err_exp && we) ? 32'd1 : 32'd0);
        check("ready_low_busy", 32'(ready_low), 32'd1);
        @(posedge clk);
        #1;
        check("resp_pulse_single", 32'(bus.resp_valid), 32'd0);
        check("ready_after_resp", 32'(bus.req_ready), 32'd1);
        if (!err_exp && we) ref_mem[widx] = new_w;
    endtask

    logic [31:0] rd;
    logic [31:0] ra;

    initial begin
        for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = init_word(i);
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        rst_n = 1'b0; ram_init = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_r_addr), 32'd0);
        ram_init = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed sequence.
        run_req(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 1'b0, rd);
        run_req(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, rd);
        check("lw_deadbeef", rd, 32'hDEAD_BEEF);
        run_req(1'b1, 3'b000, 32'h101, 32'h0000_0055, 1'b0, rd);
        run_req(1'b1, 3'b001, 32'h102, 32'h0000_1234, 1'b0, rd);
        run_req(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, rd);
        check("lw_merged", rd, 32'h1234_55EF);
        run_req(1'b0, 3'b000, 32'h100, 32'h0, 1'b0, rd);
        check("lb_sext", rd, 32'hFFFF_FFEF);
        run_req(1'b0, 3'b100, 32'h100, 32'h0, 1'b0, rd);
        check("lbu_zext", rd, 32'h0000_00EF);
        run_req(1'b0, 3'b001, 32'h102, 32'h0, 1'b0, rd);
        check("lh_hi", rd, 32'h0000_1234);
        run_req(1'b0, 3'b101, 32'h100, 32'h0, 1'b0, rd);
        check("lhu_lo", rd, 32'h0000_55EF);
        run_req(1'b0, 3'b010, 32'h102, 32'h0, 1'b0, rd);
        run_req(1'b1, 3'b001, 32'h101, 32'hFFFF_FFFF, 1'b0, rd);
        run_req(1'b0, 3'b011, 32'h100, 32'h0, 1'b0, rd);
        run_req(1'b0, 3'b010, 32'h1_0000, 32'h0, 1'b0, rd);
        run_req(1'b1, 3'b010, 32'h1_0000, 32'h1111_1111, 1'b0, rd);
        run_req(1'b0, 3'b010, 32'h0_FFFC, 32'h0, 1'b0, rd);

        // req_valid held high across two requests.
        run_req(1'b1, 3'b010, 32'h108, 32'hCAFE_F00D, 1'b1, rd);
        run_req(1'b0, 3'b010, 32'h108, 32'h0, 1'b0, rd);
        check("b2b_load", rd, 32'hCAFE_F00D);

        // Reset asserted during RD of a sub-word store.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h104; bus.req_wdata = 32'h0000_00AA;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ram_we", 32'(ram_we), 32'd0);
        check("midrst_ready", 32'(bus.req_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("midrst_hold_we", 32'(ram_we), 32'd0);
            check("midrst_hold_resp", 32'(bus.resp_valid), 32'd0);
            if (c == 1) rst_n = 1'b1;
        end
        check("midrst_ready_rel", 32'(bus.req_ready), 32'd1);
        run_req(1'b0, 3'b010, 32'h104, 32'h0, 1'b0, rd);
        check("midrst_orig_word", rd, init_word(32'h41));

        // Randomized traffic.
        for (int n = 0; n < 250; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r == 0)      ra = $urandom;
            else if (r == 1) ra = 32'h0000_FFF0 + 32'($urandom_range(0, 31));
            else             ra = 32'h100 + 32'($urandom_range(0, 63));
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, 1'b0, rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store front end that sits directly upstream of the word-addressed data RAM: a 1-cycle synchronous-read RAM, 32-bit words, 14-bit word address, write-enable only, no byte enables.
The block accepts byte-addressed RV32 load/store requests from the core (LB/LH/LW/LBU/LHU/SB/SH/SW).
It issues RAM read/write cycles, performing read-modify-write for sub-word stores, and returns formatted, sign- or zero-extended load data.
It detects misaligned, out-of-range and illegal-width requests and reports them without touching the RAM.

Parameters:
ADDR_W, 14, RAM word-address width.
MEM_WORDS, 16384, number of valid words; word index >= MEM_WORDS is out of range.

Ports:
clk  in  1  clock; everything in this block changes only on its rising edge, except the asynchronous reset below.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  core request present.
req_ready  out  1  block can accept a request (high only in IDLE).
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32 width/sign code.
req_addr  in  32  byte address.
req_wdata  in  32  store data (low bits used for SB/SH).
resp_valid  out  1  single-cycle response pulse.
resp_rdata  out  32  formatted load data (0 for stores and errors).
resp_err  out  1  request rejected, valid with resp_valid.
ram_we  out  1  RAM write enable.
ram_r_addr  out  ADDR_W  RAM read word address.
ram_r_data  in  32  RAM read data, valid the cycle after ram_r_addr is sampled.
ram_w_addr  out  ADDR_W  RAM write word address.
ram_w_data  out  32  RAM write data.

Behaviour:
- Handshake and latching: a request is accepted on a rising edge with req_valid && req_ready. addr, we, funct3 and wdata are latched at that edge. req_ready = (state == IDLE).
- RAM addresses: ram_r_addr = ram_w_addr = latched addr[ADDR_W+1:2].
- Error check at acceptance: resp_err is set when any of the following holds.
  - funct3 not in {000, 001, 010, 100, 101} for loads, or not in {000, 001, 010} for stores.
  - Half access with addr[0] != 0.
  - Word access with addr[1:0] != 0.
  - addr[31:2] >= MEM_WORDS.
  An errored request goes straight to RESP and causes no RAM write.
- States:
  - IDLE: accepting; on a good load or a good SB/SH go to RD; on a good SW go to WR; on an error go to RESP.
  - RD: RAM samples ram_r_addr at the end of this cycle; go to DATA.
  - DATA: ram_r_data is valid.
    - Load: extract the byte at addr[1:0]*8, or the half at addr[1]*16, or the word. Sign-extend for 000/001, zero-extend for 100/101. Register the result into resp_rdata.
    - SB/SH: ram_we = 1 and ram_w_data = ram_r_data with the addressed byte/half replaced by req_wdata[7:0]/[15:0] (little-endian).
    - Go to RESP.
  - WR: ram_we = 1, ram_w_data = req_wdata; go to RESP.
  - RESP: resp_valid = 1 for exactly one cycle; go to IDLE.
- Latency, counted in cycles after the accepting edge, is the cycle in which resp_valid is high:
  - Load, SB and SH: 3.
  - SW: 2.
  - Error: 1.
- Back-to-back: the next request can be accepted at the end of the first IDLE cycle after RESP.
- ram_we is 0 in every state except WR and the DATA state of a sub-word store.
- resp_rdata and resp_err hold their value until the next response is loaded. Both are 0 for store responses; resp_rdata is 0 for errors.
- No response back-pressure: the core must sample resp_valid when it pulses.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, ram_we 0, latched address 0.
- Reset mid-operation: state returns to IDLE asynchronously and ram_we drops immediately. An in-flight store whose write edge has not yet occurred leaves memory unchanged. No response is produced for the aborted request.

Test Plan:
- Aligned word: SW addr 0x100 data 0xDEADBEEF (resp 2 cycles, ram_we one cycle at word 0x40), then LW 0x100 -> resp_rdata 0xDEADBEEF, resp_err 0, resp_valid 3 cycles after accept.
- Sub-word stores: SB 0x101 data 0x55, then SH 0x102 data 0x1234 onto word 0xDEADBEEF -> LW 0x100 returns 0x123455EF. Each sub-word store does exactly one read then one write.
- Loads: LB 0x100 from 0x123455EF -> 0xFFFFFFEF; LBU -> 0x000000EF; LH 0x102 -> 0x00001234; LHU 0x100 -> 0x000055EF.
- Errors, each giving resp_err 1, resp_rdata 0, latency 1, ram_we never high:
  - LW 0x102.
  - SH 0x101.
  - funct3 011 load.
  - LW 0x10000 with MEM_WORDS 16384.
- Handshake: hold req_valid high across two requests -> req_ready is low from accept through RESP, and the second request is accepted only in IDLE.
- Reset mid-op: assert rst_n low during RD of an SB to 0x104 -> ram_we stays 0, resp_valid stays 0, a later LW 0x104 returns the original word, req_ready is 1 after release.
